fifo8_16: RTL
=============

# fifo8_16

Eight-entry, 16-bit synchronous FIFO built from eight 16-bit storage registers, a 3-bit write pointer, and a 3-bit read pointer. The read data path is a single 8-way 16-bit selection of the storage register at the read pointer. The block sits directly upstream of an 8-way 16-bit word mux and owns the storage and pointer logic that drives its data inputs and select. It buffers words between a producer and a consumer in the same clock domain, with show-ahead read data.

## Interface
Parameters: none. Depth is fixed at 8 and width at 16.

Ports:
- `clk` input 1: single clock. All state updates on the rising edge.
- `reset` input 1: synchronous, active-high. Clears all state.
- `in` input 16: write data.
- `push` input 1: write request.
- `pop` input 1: read request.
- `out` output 16: word at the head of the FIFO (show-ahead).
- `empty` output 1: high when count == 0.
- `full` output 1: high when count == 8.
- `count` output 4: number of stored words, 0..8.
- `overflow` output 1: sticky error flag. Present only with `FIFO8_ERRFLAG_EN`.
- `underflow` output 1: sticky error flag. Present only with `FIFO8_ERRFLAG_EN`.

## Operation
Reset values:
- `wr_ptr`, `rd_ptr` = 0.
- `count` = 0.
- All storage registers = 16'h0000.
- Outputs: `out` = 0, `empty` = 1, `full` = 0, `overflow` = `underflow` = 0.

Accepted operations:
- Push is accepted when `push` && (!`full` || `pop`).
- Pop is accepted when `pop` && !`empty`.

On an accepted push:
- `mem[wr_ptr]` <= `in`.
- `wr_ptr` <= `wr_ptr` + 1, mod 8 (natural 3-bit wrap from 7 to 0).

On an accepted pop:
- `rd_ptr` <= `rd_ptr` + 1, mod 8.
- Storage is not cleared.

Count update:
- `count` increments on push-only, decrements on pop-only, and is unchanged on both or neither.

Outputs:
- `out` = `mem[rd_ptr]`, combinational from the registers.
- `empty` and `full` decode from `count`, not from pointer equality.

Boundary cases:
- Push while full with no pop: ignored. Storage, pointers and count unchanged.
- Pop while empty: ignored. `out` shows the stale `mem[rd_ptr]`, and the consumer must qualify it with `empty`.
- Push and pop together while full: both accepted. Count stays 8, and `in` overwrites the slot being vacated.
- Push and pop together while empty: push accepted, pop ignored. Count becomes 1.
- Push and pop together in any other state: both accepted. Count unchanged.

Reset:
- `reset` overrides `push` and `pop` in the same cycle.
- Reset mid-operation discards all contents.

## Timing
- Write latency: a word pushed at edge N appears on `out` after edge N when the FIFO was empty, i.e. it is valid in cycle N+1.
- Read latency: 0. `out` reflects the head combinationally. After a pop at edge N, the next word is on `out` in cycle N+1.
- `count`, `empty` and `full` update on the same edge as the operation that changes them.
- Throughput: one push and one pop per cycle, sustained.
- Combinational paths: none from `push`/`pop` to `out`, `empty`, `full` or `count`. All flags are registered or decoded from registered state.

## Configuration
- `FIFO8_ERRFLAG_EN` defined:
  - `overflow` sets on a rejected push (`push` && `full` && !`pop`).
  - `underflow` sets on a rejected pop (`pop` && `empty`).
  - Both flags are sticky until `reset`.
  - Both flags set on the edge following the offending request.
- `FIFO8_ERRFLAG_EN` undefined: the `overflow` and `underflow` ports and their logic are absent. All other behaviour is identical.

## Test plan
- Reset, then push 16'h0001 through 16'h0008 on eight consecutive cycles -> `count` goes 1..8; `full` = 1 after the 8th edge; `out` = 16'h0001 throughout.
- From full, pop eight times -> `out` sequence 0001..0008, one per cycle; `empty` = 1 after the 8th edge; `count` = 0.
- Wrap-around: push 5, pop 5, push 8 words 16'hA000..16'hA007, then pop 8 -> data returns in order across the pointer wrap 7→0; `full` is asserted after the 8th push.
- Full with simultaneous push 16'hBEEF and pop -> `count` stays 8; the old head leaves; 16'hBEEF is read as the 8th pop after it.
- Empty with simultaneous push 16'h1234 and pop -> `count` = 1, `out` = 16'h1234. A second pop while empty -> ignored, and with `FIFO8_ERRFLAG_EN` `underflow` = 1.
- Mid-fill reset: push 3 words, assert `reset` together with `push` -> next cycle `count` = 0, `empty` = 1, `out` = 0, and the push is discarded.

Source files
------------

// File: rtl/fifo8_16.sv
// fifo8_16: eight-entry, 16-bit synchronous FIFO with show-ahead read data.
// Storage is eight 16-bit registers addressed by 3-bit write/read pointers
// that wrap naturally from 7 to 0. Occupancy is tracked by a separate 4-bit
// counter so empty/full never depend on pointer comparison.
// Optional feature macro: FIFO8_ERRFLAG_EN adds sticky overflow/underflow flags.
module fifo8_16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        push,
  input  logic        pop,
  output logic [15:0] out,
  output logic        empty,
  output logic        full,
  output logic [3:0]  count
`ifdef FIFO8_ERRFLAG_EN
  ,
  output logic        overflow,
  output logic        underflow
`endif
);

  logic [15:0] mem_q [8];
  logic [2:0]  wrPtr_q;
  logic [2:0]  wrPtr_d;
  logic [2:0]  rdPtr_q;
  logic [2:0]  rdPtr_d;
  logic [3:0]  count_q;
  logic [3:0]  count_d;
  logic        pushOk;
  logic        popOk;

  // A push into a full FIFO still goes through when a pop frees the head slot
  // on the same edge; a pop from an empty FIFO never does.
  assign pushOk = push && (!full || pop);
  assign popOk  = pop && !empty;

  // Flags and read data decode only from registered state.
  assign out   = mem_q[rdPtr_q];
  assign empty = (count_q == 4'd0);
  assign full  = (count_q == 4'd8);
  assign count = count_q;

  // Next pointer and occupancy values from the accepted operations.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (pushOk) begin
      wrPtr_d = wrPtr_q + 3'd1;
    end
    if (popOk) begin
      rdPtr_d = rdPtr_q + 3'd1;
    end
    case ({pushOk, popOk})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  // Pointer, counter and storage registers; reset wipes every slot to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= 3'd0;
      rdPtr_q <= 3'd0;
      count_q <= 4'd0;
      for (int i = 0; i < 8; i++) begin
        mem_q[i] <= 16'h0000;
      end
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      if (pushOk) begin
        mem_q[wrPtr_q] <= in;
      end
    end
  end

`ifdef FIFO8_ERRFLAG_EN
  logic overflow_q;
  logic overflow_d;
  logic underflow_q;
  logic underflow_d;

  // Error flags latch on any rejected request and hold until reset.
  always_comb begin
    overflow_d  = overflow_q  | (push && full && !pop);
    underflow_d = underflow_q | (pop && empty);
  end

  // Sticky error flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule
